// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states,
// instruction field positions and the idle datapath control word.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_FETCH_EXT = 3'd2,
        S_EXEC      = 3'd3,
        S_MEM_WAIT  = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_ALU  = 4'd1;
    localparam logic [3:0] OPC_ALUI = 4'd2;
    localparam logic [3:0] OPC_LD   = 4'd3;
    localparam logic [3:0] OPC_ST   = 4'd4;
    localparam logic [3:0] OPC_JMP  = 4'd5;
    localparam logic [3:0] OPC_JC   = 4'd6;
    localparam logic [3:0] OPC_JZ   = 4'd7;
    localparam logic [3:0] OPC_HALT = 4'd8;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int ALUC_HI = 27;
    localparam int ALUC_LO = 24;
    localparam int C_HI    = 23;
    localparam int C_LO    = 18;
    localparam int A_HI    = 17;
    localparam int A_LO    = 12;
    localparam int B_HI    = 11;
    localparam int B_LO    = 6;
    localparam int SH_HI   = 5;
    localparam int SH_LO   = 4;

    typedef struct packed {
        logic [5:0] sel_a;
        logic [5:0] sel_b;
        logic [5:0] c_sel;
        logic [3:0] aluc;
        logic [1:0] shift;
        logic       kmx;
        logic       mw;
        logic       mr;
        logic       cy;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

    // ALUI, LD, ST and the three jumps carry an extension word.
    function automatic logic is_two_word(input logic [3:0] opc);
        return (opc >= OPC_ALUI) && (opc <= OPC_JZ);
    endfunction

    function automatic logic is_illegal(input logic [3:0] opc);
        return opc > OPC_HALT;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction, extension word and FSM
// state into the datapath control word, K constant and data-memory address.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int IW   = 32,
    parameter int DW   = 16
) (
    input  state_e            state_i,
    input  logic [IW-1:0]     ir_i,
    input  logic [IW-1:0]     ext_i,
    input  logic              cf_i,
    input  logic              mem_rdy_i,
    output ctrl_word_t        ctrl_o,
    output logic [DW-1:0]     k_o,
    output logic [PC_W-1:0]   mem_addr_o,
    output logic              illegal_o
);

    localparam int EXT_W = (DW > PC_W) ? DW : PC_W;

    logic [3:0] opc;
    logic [3:0] fld_aluc;
    logic [5:0] fld_c;
    logic [5:0] fld_a;
    logic [5:0] fld_b;
    logic [1:0] fld_sh;
    logic       unused_bits;

    assign opc      = ir_i[OPC_HI:OPC_LO];
    assign fld_aluc = ir_i[ALUC_HI:ALUC_LO];
    assign fld_c    = ir_i[C_HI:C_LO];
    assign fld_a    = ir_i[A_HI:A_LO];
    assign fld_b    = ir_i[B_HI:B_LO];
    assign fld_sh   = ir_i[SH_HI:SH_LO];

    assign unused_bits = ^{ir_i[SH_LO-1:0], ext_i[IW-1:EXT_W]};

    always_comb begin
        ctrl_o     = CTRL_IDLE;
        k_o        = '0;
        mem_addr_o = '0;
        illegal_o  = 1'b0;
        case (state_i)
            S_DECODE: illegal_o = is_illegal(opc);
            S_EXEC, S_MEM_WAIT: begin
                case (opc)
                    OPC_ALU, OPC_ALUI: begin
                        ctrl_o.sel_a = fld_a;
                        ctrl_o.sel_b = fld_b;
                        ctrl_o.c_sel = fld_c;
                        ctrl_o.aluc  = fld_aluc;
                        ctrl_o.shift = fld_sh;
                        ctrl_o.cy    = cf_i;
                        if (opc == OPC_ALUI) begin
                            ctrl_o.kmx = 1'b1;
                            k_o        = ext_i[DW-1:0];
                        end
                    end
                    // A load only commits to the register bank in the
                    // cycle the memory reports its data ready.
                    OPC_LD: begin
                        ctrl_o.mr  = 1'b1;
                        mem_addr_o = ext_i[PC_W-1:0];
                        if (mem_rdy_i) begin
                            ctrl_o.c_sel = fld_c;
                        end
                    end
                    OPC_ST: begin
                        ctrl_o.mw    = 1'b1;
                        ctrl_o.sel_a = fld_a;
                        mem_addr_o   = ext_i[PC_W-1:0];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer: owns the FSM, program counter, instruction
// and extension registers and the carry/zero flags; decode is delegated.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int IW   = 32,
    parameter int DW   = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [PC_W-1:0] PC,
    output logic            IMEM_REQ,
    input  logic            IMEM_ACK,
    input  logic [IW-1:0]   IMEM_DATA,
    input  logic [DW-1:0]   W_IN,
    input  logic            CY_FROM_ALU,
    input  logic            MEM_RDY,
    output logic [5:0]      SEL_A_RB,
    output logic [5:0]      SEL_B_RB,
    output logic [5:0]      C_SEL_RB,
    output logic [3:0]      ALUC,
    output logic [1:0]      SHIFTER_SEL,
    output logic            Y_X_KMX_SEL,
    output logic [DW-1:0]   K_OUT,
    output logic [PC_W-1:0] MEM_ADDR,
    output logic            MW,
    output logic            MR,
    output logic            CY_TO_ALU,
    output logic            HALTED,
    output logic            ILLEGAL
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [IW-1:0]   ext_q, ext_d;
    logic            cf_q, cf_d;
    logic            zf_q, zf_d;
    logic [3:0]      opc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    ctrl_word_t      ctrl;

    assign opc    = ir_q[OPC_HI:OPC_LO];
    assign pc_inc = pc_q + PC_W'(1);
    assign target = ext_q[PC_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ext_q   <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ext_q   <= ext_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ext_d   = ext_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        case (state_q)
            S_FETCH: begin
                if (IMEM_ACK) begin
                    ir_d    = IMEM_DATA;
                    pc_d    = pc_inc;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == OPC_HALT) begin
                    state_d = S_HALT;
                end else if (is_two_word(opc)) begin
                    state_d = S_FETCH_EXT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_FETCH_EXT: begin
                if (IMEM_ACK) begin
                    ext_d   = IMEM_DATA;
                    pc_d    = pc_inc;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opc)
                    OPC_ALU, OPC_ALUI: begin
                        cf_d = CY_FROM_ALU;
                        zf_d = (W_IN == '0);
                    end
                    OPC_LD, OPC_ST: begin
                        if (!MEM_RDY) begin
                            state_d = S_MEM_WAIT;
                        end
                    end
                    OPC_JMP: pc_d = target;
                    OPC_JC:  if (cf_q) pc_d = target;
                    OPC_JZ:  if (zf_q) pc_d = target;
                    default: ;
                endcase
            end
            S_MEM_WAIT: begin
                if (MEM_RDY) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    ctrl_decode #(
        .PC_W (PC_W),
        .IW   (IW),
        .DW   (DW)
    ) u_decode (
        .state_i    (state_q),
        .ir_i       (ir_q),
        .ext_i      (ext_q),
        .cf_i       (cf_q),
        .mem_rdy_i  (MEM_RDY),
        .ctrl_o     (ctrl),
        .k_o        (K_OUT),
        .mem_addr_o (MEM_ADDR),
        .illegal_o  (ILLEGAL)
    );

    // The request is gated by reset so it is low while the FSM is held in FETCH.
    assign IMEM_REQ    = RST_N && ((state_q == S_FETCH) || (state_q == S_FETCH_EXT));
    assign PC          = pc_q;
    assign HALTED      = (state_q == S_HALT);
    assign SEL_A_RB    = ctrl.sel_a;
    assign SEL_B_RB    = ctrl.sel_b;
    assign C_SEL_RB    = ctrl.c_sel;
    assign ALUC        = ctrl.aluc;
    assign SHIFTER_SEL = ctrl.shift;
    assign Y_X_KMX_SEL = ctrl.kmx;
    assign MW          = ctrl.mw;
    assign MR          = ctrl.mr;
    assign CY_TO_ALU   = ctrl.cy;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: program memory and data-memory responders,
// a scoreboard of expected control-word observations and direct state checks.
module tb_ctrl_sequencer;

    localparam int OBS_W = 65;
    localparam logic [31:0] HALT_W = 32'h8000_0000;

    logic        CLK;
    logic        RST_N;
    logic [9:0]  PC;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic [15:0] W_IN;
    logic        CY_FROM_ALU;
    logic        MEM_RDY;
    logic [5:0]  SEL_A_RB, SEL_B_RB, C_SEL_RB;
    logic [3:0]  ALUC;
    logic [1:0]  SHIFTER_SEL;
    logic        Y_X_KMX_SEL;
    logic [15:0] K_OUT;
    logic [9:0]  MEM_ADDR;
    logic        MW, MR, CY_TO_ALU, HALTED, ILLEGAL;

    logic [31:0]      imem [0:1023];
    logic [OBS_W-1:0] exp_q[$];
    int               checks;
    int               errors;
    int               ack_delay;
    int               mem_delay;
    logic             mon_en;
    int               cyc;
    int               first_obs_cyc;

    ctrl_sequencer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PC          (PC),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_DATA   (IMEM_DATA),
        .W_IN        (W_IN),
        .CY_FROM_ALU (CY_FROM_ALU),
        .MEM_RDY     (MEM_RDY),
        .SEL_A_RB    (SEL_A_RB),
        .SEL_B_RB    (SEL_B_RB),
        .C_SEL_RB    (C_SEL_RB),
        .ALUC        (ALUC),
        .SHIFTER_SEL (SHIFTER_SEL),
        .Y_X_KMX_SEL (Y_X_KMX_SEL),
        .K_OUT       (K_OUT),
        .MEM_ADDR    (MEM_ADDR),
        .MW          (MW),
        .MR          (MR),
        .CY_TO_ALU   (CY_TO_ALU),
        .HALTED      (HALTED),
        .ILLEGAL     (ILLEGAL)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            if (!RST_N) cyc = 0;
            else        cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc(input logic [3:0] opc, input logic [3:0] aluc,
                                        input logic [5:0] c, input logic [5:0] a,
                                        input logic [5:0] b, input logic [1:0] sh);
        return {opc, aluc, c, a, b, sh, 4'h0};
    endfunction

    function automatic logic [OBS_W-1:0] mk_obs(
        input logic [9:0] pc, input logic [5:0] sa, input logic [5:0] sb, input logic [5:0] cs,
        input logic [3:0] aluc, input logic [1:0] sh, input logic kmx, input logic [15:0] k,
        input logic [9:0] ma, input logic mw, input logic mr, input logic cy, input logic ill);
        return {pc, sa, sb, cs, aluc, sh, kmx, k, ma, mw, mr, cy, ill};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        exp_q.delete();
        first_obs_cyc = -1;
        @(negedge CLK); #2;
        check("reset_state",
              {54'd0, PC},
              64'd0);
        check("reset_outputs",
              {IMEM_REQ, HALTED, ILLEGAL, MR, MW, Y_X_KMX_SEL, CY_TO_ALU, C_SEL_RB, SEL_A_RB},
              64'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    task automatic finish_prog(input string name, input logic [9:0] exp_pc);
        int n;
        n = 0;
        while (!HALTED && n < 300) begin
            @(negedge CLK); #2;
            n++;
        end
        check({name, "_halted"}, {63'd0, HALTED}, 64'd1);
        repeat (2) begin
            @(negedge CLK); #2;
        end
        check({name, "_pc"}, {54'd0, PC}, {54'd0, exp_pc});
        check({name, "_req_low"}, {63'd0, IMEM_REQ}, 64'd0);
        check({name, "_drain"}, exp_q.size(), 64'd0);
    endtask

    // ---------------- driver-side responders ----------------
    initial begin : imem_resp
        int wcnt;
        wcnt = 0;
        IMEM_ACK = 1'b0;
        IMEM_DATA = '0;
        forever begin
            @(negedge CLK);
            if (IMEM_REQ) begin
                IMEM_DATA = imem[PC];
                if (wcnt < ack_delay) begin
                    IMEM_ACK = 1'b0;
                    wcnt++;
                end else begin
                    IMEM_ACK = 1'b1;
                    wcnt = 0;
                end
            end else begin
                IMEM_ACK = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin : dmem_resp
        int mcnt;
        mcnt = 0;
        MEM_RDY = 1'b0;
        forever begin
            @(negedge CLK);
            if (MR || MW) begin
                if (mcnt < mem_delay) begin
                    MEM_RDY = 1'b0;
                    mcnt++;
                end else begin
                    MEM_RDY = 1'b1;
                    mcnt = 0;
                end
            end else begin
                MEM_RDY = 1'b0;
                mcnt = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [OBS_W-1:0] got;
        logic [OBS_W-1:0] exp;
        forever begin
            @(negedge CLK); #2;
            if (RST_N && mon_en &&
                (C_SEL_RB != 6'd0 || MR || MW || Y_X_KMX_SEL || ILLEGAL)) begin
                got = mk_obs(PC, SEL_A_RB, SEL_B_RB, C_SEL_RB, ALUC, SHIFTER_SEL, Y_X_KMX_SEL,
                             K_OUT, MEM_ADDR, MW, MR, CY_TO_ALU, ILLEGAL);
                if (first_obs_cyc < 0) first_obs_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL obs_unexpected got=%h exp=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL obs_compare got=%h exp=%h", got, exp);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks = 0;
        errors = 0;
        RST_N = 1'b0;
        ack_delay = 0;
        mem_delay = 0;
        mon_en = 1'b1;
        first_obs_cyc = -1;
        W_IN = 16'd1;
        CY_FROM_ALU = 1'b0;

        // Test 1: single-word ALU op, EXEC in the third cycle.
        clear_imem();
        imem[0] = enc(4'd1, 4'hA, 6'd1, 6'd0, 6'd4, 2'd0);
        do_reset();
        exp_q.push_back(mk_obs(10'd1, 6'd0, 6'd4, 6'd1, 4'hA, 2'd0, 1'b0, 16'h0, 10'h0,
                               1'b0, 1'b0, 1'b0, 1'b0));
        finish_prog("alu_rr", 10'd2);
        check("alu_rr_latency", first_obs_cyc, 64'd2);

        // Test 2: ALUI sets CF, JC taken, following ALU sees CF on CY_TO_ALU.
        clear_imem();
        imem[0]    = enc(4'd2, 4'd3, 6'd2, 6'd1, 6'd0, 2'd0);
        imem[1]    = 32'h0000_1234;
        imem[2]    = enc(4'd6, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        imem[3]    = 32'h0000_0055;
        imem[4]    = enc(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        imem[10'h55] = enc(4'd1, 4'd6, 6'd7, 6'd3, 6'd2, 2'd1);
        CY_FROM_ALU = 1'b1;
        W_IN = 16'd5;
        do_reset();
        exp_q.push_back(mk_obs(10'd2, 6'd1, 6'd0, 6'd2, 4'd3, 2'd0, 1'b1, 16'h1234, 10'h0,
                               1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk_obs(10'h56, 6'd3, 6'd2, 6'd7, 4'd6, 2'd1, 1'b0, 16'h0, 10'h0,
                               1'b0, 1'b0, 1'b1, 1'b0));
        finish_prog("jc_taken", 10'h57);
        check("alui_latency", first_obs_cyc, 64'd3);

        // Test 2b: CF=0 so JC falls through; ZF=1 so JZ is taken.
        clear_imem();
        imem[0] = enc(4'd2, 4'd3, 6'd2, 6'd1, 6'd0, 2'd0);
        imem[1] = 32'h0000_1234;
        imem[2] = enc(4'd6, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        imem[3] = 32'h0000_0055;
        imem[4] = enc(4'd7, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        imem[5] = 32'h0000_0100;
        CY_FROM_ALU = 1'b0;
        W_IN = 16'd0;
        do_reset();
        exp_q.push_back(mk_obs(10'd2, 6'd1, 6'd0, 6'd2, 4'd3, 2'd0, 1'b1, 16'h1234, 10'h0,
                               1'b0, 1'b0, 1'b0, 1'b0));
        finish_prog("jc_untaken_jz", 10'h101);

        // Test 3: LD and ST with three wait cycles each.
        clear_imem();
        imem[0] = enc(4'd3, 4'd0, 6'd5, 6'd7, 6'd0, 2'd0);
        imem[1] = 32'h0000_03FF;
        imem[2] = enc(4'd4, 4'd0, 6'd0, 6'd9, 6'd0, 2'd0);
        imem[3] = 32'h0000_0010;
        mem_delay = 3;
        W_IN = 16'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_obs(10'd2, 6'd0, 6'd0, (i == 3) ? 6'd5 : 6'd0, 4'd0, 2'd0,
                                   1'b0, 16'h0, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_obs(10'd4, 6'd9, 6'd0, 6'd0, 4'd0, 2'd0, 1'b0, 16'h0, 10'h010,
                                   1'b1, 1'b0, 1'b0, 1'b0));
        end
        finish_prog("ld_st_wait", 10'd5);
        mem_delay = 0;

        // Test 4: slow fetch acknowledge and PC wrap through 0x3FF.
        clear_imem();
        imem[0]      = enc(4'd5, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        imem[1]      = 32'h0000_03FE;
        imem[10'h3FE] = enc(4'd2, 4'd5, 6'd3, 6'd2, 6'd1, 2'd2);
        imem[10'h3FF] = 32'h0000_BEEF;
        ack_delay = 5;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #2;
            check("fetch_hold", {53'd0, IMEM_REQ, PC}, {53'd0, 1'b1, 10'd0});
        end
        n = 0;
        while (PC != 10'h3FE && n < 100) begin
            @(negedge CLK); #2;
            n++;
        end
        check("jmp_reached", {54'd0, PC}, {54'd0, 10'h3FE});
        imem[0] = HALT_W;
        exp_q.push_back(mk_obs(10'd0, 6'd2, 6'd1, 6'd3, 4'd5, 2'd2, 1'b1, 16'hBEEF, 10'h0,
                               1'b0, 1'b0, 1'b0, 1'b0));
        finish_prog("pc_wrap", 10'd1);
        ack_delay = 0;

        // Test 5: asynchronous reset while a store waits on memory.
        clear_imem();
        imem[0] = enc(4'd4, 4'd0, 6'd0, 6'd3, 6'd0, 2'd0);
        imem[1] = 32'h0000_0020;
        mem_delay = 1000;
        mon_en = 1'b0;
        do_reset();
        n = 0;
        while (!MW && n < 20) begin
            @(negedge CLK); #2;
            n++;
        end
        repeat (2) begin
            @(negedge CLK); #2;
        end
        check("st_wait_hold", {47'd0, MW, MEM_ADDR, SEL_A_RB}, {47'd0, 1'b1, 10'h020, 6'd3});
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        check("async_reset", {40'd0, CLK, MW, IMEM_REQ, PC, SEL_A_RB, MEM_ADDR},
              {40'd0, 1'b1, 1'b0, 1'b0, 10'd0, 6'd0, 10'd0});
        mon_en = 1'b1;
        mem_delay = 0;

        // Test 6: undefined opcode pulses ILLEGAL once, then HALT.
        clear_imem();
        imem[0] = enc(4'hC, 4'd0, 6'd0, 6'd0, 6'd0, 2'd0);
        do_reset();
        exp_q.push_back(mk_obs(10'd1, 6'd0, 6'd0, 6'd0, 4'd0, 2'd0, 1'b0, 16'h0, 10'h0,
                               1'b0, 1'b0, 1'b0, 1'b1));
        finish_prog("illegal", 10'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Fetch/decode/execute sequencer sitting directly upstream of the ALU/register-bank datapath (alu_reg_join).
- Fetches 32-bit microinstructions from program memory through a req/ack handshake and fetches a second extension word for immediate, memory and jump ops.
- Drives the datapath control word (register selects, ALU code, shifter, K-mux, memory strobes) and holds carry/zero flags.
- Sequences multi-cycle data-memory accesses and conditional jumps.

Parameters:
- PC_W, 10, program-counter width; also data-memory address width.
- IW, 32, instruction word width.
- DW, 16, datapath width (K constant, W feedback).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- PC  out  PC_W  program-memory address.
- IMEM_REQ  out  1  fetch request.
- IMEM_ACK  in  1  fetch acknowledge; IMEM_DATA valid this cycle.
- IMEM_DATA  in  IW  instruction/extension word.
- W_IN  in  DW  datapath result (W_Block1), used for zero flag.
- CY_FROM_ALU  in  1  datapath CY_OUT.
- MEM_RDY  in  1  data-memory access complete.
- SEL_A_RB, SEL_B_RB, C_SEL_RB  out  6 each  register selects; C_SEL_RB=0 means no write.
- ALUC  out  4  ALU function.
- SHIFTER_SEL  out  2  shifter mode.
- Y_X_KMX_SEL  out  1  1 selects the K constant as the ALU Y operand.
- K_OUT  out  DW  immediate constant.
- MEM_ADDR  out  PC_W  data-memory address.
- MW, MR  out  1 each  memory write/read strobes.
- CY_TO_ALU  out  1  carry flag to datapath CY_IN.
- HALTED  out  1  sequencer stopped.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Instruction fields:
  - [31:28] OPC
  - [27:24] ALUC
  - [23:18] C
  - [17:12] A
  - [11:6] B
  - [5:4] SHIFT
  - [3:0] reserved, ignored.
- Extension word:
  - [15:0] K for ALUI.
  - [PC_W-1:0] address/target for LD, ST and jumps.
- OPC decode:
  - 0 NOP.
  - 1 ALU reg-reg.
  - 2 ALUI (two words).
  - 3 LD (two words).
  - 4 ST (two words).
  - 5 JMP, 6 JC, 7 JZ (two words).
  - 8 HALT.
  - 9-15: ILLEGAL pulse, then executed as NOP.
- Reset (async, immediate on RST_N low):
  - State=FETCH, PC=0, CF=ZF=0.
  - All control outputs 0, IMEM_REQ=0, HALTED=0, ILLEGAL=0.
  - A fetch or memory access in progress is abandoned; strobes drop in the same instant.
- States:
  - FETCH: IMEM_REQ=1, PC stable. On IMEM_ACK, latch IR, PC+=1, go to DECODE.
  - DECODE (1 cycle): two-word op goes to FETCH_EXT; HALT goes to HALT; else EXEC.
  - FETCH_EXT: same handshake as FETCH. Latch EXT, PC+=1, go to EXEC.
  - EXEC (1 cycle, control outputs registered, valid exactly this cycle):
    - ALU/ALUI: drive A, B, C, ALUC, SHIFT, CY_TO_ALU=CF; Y_X_KMX_SEL=1 and K_OUT=EXT[15:0] for ALUI. At the end of the cycle, CF<=CY_FROM_ALU and ZF<=(W_IN==0).
    - LD: MR=1, MEM_ADDR=EXT, C_SEL_RB=0 until MEM_RDY. If MEM_RDY=1 this cycle, assert C_SEL_RB=C in the same cycle and go to FETCH; else go to MEM_WAIT.
    - ST: MW=1, MEM_ADDR=EXT, SEL_A_RB=A. Go to FETCH on MEM_RDY; else MEM_WAIT.
    - JMP: PC<=EXT. JC: PC<=EXT if CF. JZ: PC<=EXT if ZF. Untaken jump leaves PC unchanged. Flags unchanged.
    - NOP: outputs idle.
  - MEM_WAIT: hold MR/MW, MEM_ADDR, selects. For LD, C_SEL_RB=C only in the cycle MEM_RDY=1. Exit to FETCH on MEM_RDY.
  - HALT: outputs idle, HALTED=1, terminal until reset.
- Outside EXEC/MEM_WAIT: C_SEL_RB=0, MW=MR=0, Y_X_KMX_SEL=0.
- PC wraps modulo 2^PC_W; incrementing from all-ones yields 0.
- IMEM_ACK outside FETCH/FETCH_EXT is ignored.
- MEM_RDY outside MEM access is ignored.
- Minimum latency: single-word op 3 cycles (FETCH with immediate ack, DECODE, EXEC); two-word op 4 cycles.

Decomposition:
- Package ctrl_pkg holds:
  - the OPC constants;
  - the state encoding (FETCH, DECODE, FETCH_EXT, EXEC, MEM_WAIT, HALT);
  - instruction field bit positions;
  - the idle control-word constant.
- One sub-module, ctrl_decode: combinational IR/EXT/state to control-word decode. The FSM, PC and flags stay in ctrl_sequencer.

Test Plan:
- Reset, then IMEM_ACK always 1 with word 0x1A_1_0_4_0 pattern (OPC=1, ALUC=0xA, C=1, A=0, B=4): EXEC in cycle 3 drives ALUC=0xA, C_SEL_RB=1, SEL_B_RB=4, Y_X_KMX_SEL=0, PC=1 afterwards.
- ALUI with EXT=0x00001234: EXEC shows Y_X_KMX_SEL=1 and K_OUT=0x1234. CY_FROM_ALU=1 gives CF=1, so a following JC to 0x055 sets PC=0x055. With CF=0, PC advances by 2 instead.
- LD C=5, EXT=0x3FF, MEM_RDY low 3 cycles: MR held 4 cycles with MEM_ADDR=0x3FF; C_SEL_RB=5 only in the MEM_RDY cycle, 0 before.
- IMEM_ACK delayed 5 cycles: IMEM_REQ held and PC stable; PC=0x3FF fetch wraps PC to 0.
- RST_N low during MEM_WAIT of ST: MW drops immediately (no clock edge) and PC=0. OPC=0xC raises ILLEGAL for one cycle. HALT asserts HALTED and IMEM_REQ stays 0.
